arb_seq_checker: RTL and testbench

//  Receive-side checker for the 7-state arbitrary-code counter, which emits 0 once after reset
//  and then repeats 2,5,3,4,6,1. It samples the 4-bit code stream, decodes each code to its ordinal

---
 rtl/arb_seq_checker.sv | 152 +++++++++++++++
 tb/tb_arb_seq_checker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/arb_seq_checker.sv
// Tracks the 0,(2,5,3,4,6,1)* code stream and locks onto it; flags and counts out-of-sequence codes.
// Latency: one cycle, since every output is registered. Backpressure: none; samples are taken only when en=1.
module arb_seq_checker #(
  parameter int LOCK_N = 3,
  parameter int LOSS_N = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       cq,
  input  logic             err_clr,
  output logic [2:0]       pos,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int GW = $clog2(LOCK_N + 1);
  localparam int BW = $clog2(LOSS_N + 1);

  function automatic logic [2:0] succ(input logic [2:0] c);
    case (c)
      3'd0:    return 3'd2;
      3'd2:    return 3'd5;
      3'd5:    return 3'd3;
      3'd3:    return 3'd4;
      3'd4:    return 3'd6;
      3'd6:    return 3'd1;
      3'd1:    return 3'd2;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [2:0] code_pos(input logic [2:0] c);
    case (c)
      3'd0:    return 3'd0;
      3'd2:    return 3'd1;
      3'd5:    return 3'd2;
      3'd3:    return 3'd3;
      3'd4:    return 3'd4;
      3'd6:    return 3'd5;
      3'd1:    return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

  logic [1:0]    state, state_n;
  logic [2:0]    prev, prev_n;
  logic [2:0]    pos_n;
  logic [GW-1:0] good, good_n, good_inc;
  logic [BW-1:0] bad, bad_n, bad_inc;
  logic          err_n;
  logic [2:0]    exp_code;
  logic          legal, match;

  assign exp_code = succ(prev);
  assign legal    = (cq < 4'd7);
  assign match    = (cq == {1'b0, exp_code});
  assign good_inc = good + GW'(1);
  assign bad_inc  = bad + BW'(1);

  always_comb begin
    state_n = state;
    prev_n  = prev;
    pos_n   = pos;
    good_n  = good;
    bad_n   = bad;
    err_n   = 1'b0;
    if (state == 2'd3) begin
      state_n = HUNT;
    end else if (en) begin
      case (state)
        HUNT: begin
          if (legal) begin
            prev_n  = cq[2:0];
            pos_n   = code_pos(cq[2:0]);
            good_n  = '0;
            state_n = TRACK;
          end
        end
        TRACK: begin
          if (match) begin
            prev_n = cq[2:0];
            pos_n  = code_pos(cq[2:0]);
            good_n = good_inc;
            if (good_inc == GW'(LOCK_N)) begin
              state_n = LOCKED;
              bad_n   = '0;
            end
          end else if (legal) begin
            prev_n = cq[2:0];
            pos_n  = code_pos(cq[2:0]);
            good_n = '0;
          end else begin
            state_n = HUNT;
          end
        end
        default: begin
          if (match) begin
            prev_n = cq[2:0];
            pos_n  = code_pos(cq[2:0]);
            bad_n  = '0;
          end else begin
            // Flywheel: advance along the expected sequence so a single glitch keeps us in step.
            err_n  = 1'b1;
            prev_n = exp_code;
            pos_n  = code_pos(exp_code);
            bad_n  = bad_inc;
            if (bad_inc == BW'(LOSS_N)) state_n = HUNT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= HUNT;
      prev   <= 3'd0;
      pos    <= 3'd0;
      good   <= '0;
      bad    <= '0;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      prev   <= prev_n;
      pos    <= pos_n;
      good   <= good_n;
      bad    <= bad_n;
      locked <= (state_n == LOCKED);
      err    <= err_n;
    end
  end

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_n && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_arb_seq_checker.sv
// Directed and randomized checks of arb_seq_checker against a position-based sequence model.
module tb_arb_seq_checker;

  localparam int LOCK_N = 3;
  localparam int LOSS_N = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] cq = 4'd0;
  logic       err_clr = 1'b0;

  logic [2:0] pos, pos_w2;
  logic       locked, locked_w2;
  logic       err, err_w2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_w2;

  int tests = 0;
  int fails = 0;

  arb_seq_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cq(cq), .err_clr(err_clr),
    .pos(pos), .locked(locked), .err(err), .err_cnt(err_cnt)
  );

  arb_seq_checker #(.LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .en(en), .cq(cq), .err_clr(err_clr),
    .pos(pos_w2), .locked(locked_w2), .err(err_w2), .err_cnt(err_cnt_w2)
  );

  always #5 clk = ~clk;

  // Reference model: the stream is an index into seq[], wrapping from the last entry back to entry 1.
  int seq [7] = '{0, 2, 5, 3, 4, 6, 1};
  int m_mode;  // 0 hunting, 1 tracking, 2 locked
  int m_pos, m_good, m_bad, m_err, m_cnt8, m_cnt2;

  function automatic int pos_of(input int c);
    for (int i = 0; i < 7; i++) if (seq[i] == c) return i;
    return -1;
  endfunction

  function automatic int next_code();
    return seq[(m_pos == 6) ? 1 : m_pos + 1];
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
  endfunction

  function automatic void model_step(input int e, input int c, input int clr);
    int nc, p;
    nc = next_code();
    p = pos_of(c);
    m_err = 0;
    if (e != 0) begin
      if (m_mode == 0) begin
        if (p >= 0) begin m_pos = p; m_good = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (c == nc) begin
          m_pos = p; m_good++;
          if (m_good == LOCK_N) begin m_mode = 2; m_bad = 0; end
        end else if (p >= 0) begin
          m_pos = p; m_good = 0;
        end else begin
          m_mode = 0;
        end
      end else begin
        if (c == nc) begin
          m_pos = p; m_bad = 0;
        end else begin
          m_err = 1; m_pos = pos_of(nc); m_bad++;
          if (m_bad == LOSS_N) m_mode = 0;
        end
      end
    end
    if (clr != 0) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (m_err != 0) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pos"}, 32'(pos), 32'(m_pos));
    check({tag, ".locked"}, 32'(locked), (m_mode == 2) ? 32'd1 : 32'd0);
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt8));
    check({tag, ".err_cnt_w2"}, 32'(err_cnt_w2), 32'(m_cnt2));
  endtask

  task automatic step(input string tag, input logic e, input logic [3:0] c, input logic clr);
    @(negedge clk);
    en = e; cq = c; err_clr = clr;
    @(posedge clk);
    model_step(int'(e), int'(c), int'(clr));
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] rc;
    logic       re, rclr;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // 1: acquire and lock on 0,2,5,3
    step("t1", 1'b1, 4'd0, 1'b0);
    step("t1", 1'b1, 4'd2, 1'b0);
    step("t1", 1'b1, 4'd5, 1'b0);
    step("t1", 1'b1, 4'd3, 1'b0);
    check("t1.locked_const", 32'(locked), 32'd1);
    check("t1.pos_const", 32'(pos), 32'd3);

    // 2: wrap 1 -> 2
    step("t2", 1'b1, 4'd4, 1'b0);
    step("t2", 1'b1, 4'd6, 1'b0);
    step("t2", 1'b1, 4'd1, 1'b0);
    step("t2", 1'b1, 4'd2, 1'b0);
    check("t2.pos_const", 32'(pos), 32'd1);

    // 3: illegal glitch is flywheeled
    step("t3", 1'b1, 4'd5, 1'b0);
    step("t3", 1'b1, 4'd7, 1'b0);
    check("t3.err_const", 32'(err), 32'd1);
    check("t3.pos_const", 32'(pos), 32'd3);
    check("t3.cnt_const", 32'(err_cnt), 32'd1);
    step("t3", 1'b1, 4'd4, 1'b0);
    check("t3.locked_const", 32'(locked), 32'd1);

    // 4: source restart drops lock, then relock
    step("t4", 1'b1, 4'd0, 1'b0);
    step("t4", 1'b1, 4'd0, 1'b0);
    check("t4.unlocked_const", 32'(locked), 32'd0);
    check("t4.cnt_const", 32'(err_cnt), 32'd3);
    step("t4", 1'b1, 4'd2, 1'b0);
    step("t4", 1'b1, 4'd5, 1'b0);
    step("t4", 1'b1, 4'd3, 1'b0);
    step("t4", 1'b1, 4'd4, 1'b0);
    check("t4.relock_const", 32'(locked), 32'd1);

    // 5: samples with en=0 are ignored
    step("t5", 1'b1, 4'd6, 1'b0);
    step("t5", 1'b0, 4'd9, 1'b0);
    step("t5", 1'b0, 4'd0, 1'b0);
    step("t5", 1'b1, 4'd1, 1'b0);
    check("t5.pos_const", 32'(pos), 32'd6);

    // 6: saturation of the narrow counter, clear on an err cycle, async reset
    step("t6", 1'b1, 4'(next_code()), 1'b1);
    for (int i = 0; i < 5; i++) begin
      step("t6", 1'b1, 4'd7, 1'b0);
      step("t6", 1'b1, 4'(next_code()), 1'b0);
    end
    check("t6.sat_const", 32'(err_cnt_w2), 32'd3);
    check("t6.cnt8_const", 32'(err_cnt), 32'd5);
    step("t6", 1'b1, 4'd7, 1'b1);
    check("t6.clr_err_const", 32'(err), 32'd1);
    check("t6.clr_cnt_const", 32'(err_cnt_w2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t6.async_rst");
    @(negedge clk);
    rst = 1'b1;

    // Randomized stream: mostly in-sequence codes with glitches, gaps and clears
    for (int i = 0; i < 3000; i++) begin
      re = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) < 7) rc = 4'(next_code());
      else rc = 4'($urandom_range(0, 15));
      rclr = re && ($urandom_range(0, 31) == 0);
      step("rand", re, rc, rclr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
